// File: rtl/ram_sdp_param.sv
// Simple-dual-port synchronous RAM: byte-enabled write port, read port with selectable
// read-during-write behaviour and optional output register, plus a clear sweep after reset/clr.
module ram_sdp_param #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 6,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       RDW_MODE  = 0,
  parameter int unsigned       OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   read_addr,
  input  logic                clr,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                init_busy
);

  localparam int              NB      = int'(DATA_W / 8);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                run_s;
  logic                wr_in_range_s;
  logic                rd_in_range_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic [DATA_W-1:0]   rd_old_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   q_q;
  logic                q_vld_q;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     en
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (en[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // A clr in the same cycle as a request cancels that request.
  assign run_s         = (state_q == ST_RUN) && !clr;
  assign wr_in_range_s = {1'b0, write_addr} < DEPTH_A;
  assign rd_in_range_s = {1'b0, read_addr} < DEPTH_A;
  assign wr_en_s       = run_s && we && (|be) && wr_in_range_s;
  assign rd_en_s       = run_s && re;

  // Sweep sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_A) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sweep sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage array: sweep writes take priority, then byte-enabled user writes.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= CLEAR_VAL;
    end else if (wr_en_s) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[write_addr][8*i +: 8] <= data[8*i +: 8];
        end
      end
    end
  end

  // Read word selection, including same-address bypass in new-data mode.
  always_comb begin
    rd_old_s  = mem_q[read_addr];
    rd_word_s = '0;
    if (!rd_in_range_s) begin
      rd_word_s = '0;
    end else if ((RDW_MODE != 0) && wr_en_s && (write_addr == read_addr)) begin
      rd_word_s = byte_merge(rd_old_s, data, be);
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] pipe_q;
      logic              pipe_vld_q;

      // Two-stage read pipeline; a read already in stage one always completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_q     <= '0;
          pipe_vld_q <= 1'b0;
          q_q        <= '0;
          q_vld_q    <= 1'b0;
        end else begin
          pipe_vld_q <= rd_en_s;
          if (rd_en_s) begin
            pipe_q <= rd_word_s;
          end
          q_vld_q <= pipe_vld_q;
          if (pipe_vld_q) begin
            q_q <= pipe_q;
          end
        end
      end
    end else begin : g_nreg
      // Single-stage read output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_q     <= '0;
          q_vld_q <= 1'b0;
        end else begin
          q_vld_q <= rd_en_s;
          if (rd_en_s) begin
            q_q <= rd_word_s;
          end
        end
      end
    end
  endgenerate

  assign q         = q_q;
  assign q_valid   = q_vld_q;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_ram_sdp_param.sv
// Bench for ram_sdp_param: three configurations share one stimulus stream and are
// checked every cycle against a reference model, plus hand-computed literal checks.
module tb_ram_sdp_param;

  localparam int DEP  [3] = '{64, 64, 48};
  localparam int RDWM [3] = '{0, 1, 0};
  localparam int LAT  [3] = '{1, 1, 2};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic        clr   = 1'b0;
  logic [5:0]  wa    = 6'd0;
  logic [5:0]  ra    = 6'd0;
  logic [15:0] din   = 16'h0000;
  logic [1:0]  be    = 2'b00;

  logic [15:0] dq [3];
  logic        dv [3];
  logic        db [3];

  int total = 0;
  int bad   = 0;

  // model state
  logic [15:0] mm [3][64];
  int          busy [3];
  logic [15:0] sd [3][4];
  bit          sv [3][4];
  logic [15:0] eq [3];
  logic        ev [3];
  int          cyc = 0;

  always #5 clk = ~clk;

  ram_sdp_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VAL(16'h0000))
  u_dut0 (.clk(clk), .rst_n(rst_n), .we(we), .write_addr(wa), .data(din), .be(be), .re(re),
          .read_addr(ra), .clr(clr), .q(dq[0]), .q_valid(dv[0]), .init_busy(db[0]));

  ram_sdp_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .RDW_MODE(1), .OUT_REG(0), .CLEAR_VAL(16'h0000))
  u_dut1 (.clk(clk), .rst_n(rst_n), .we(we), .write_addr(wa), .data(din), .be(be), .re(re),
          .read_addr(ra), .clr(clr), .q(dq[1]), .q_valid(dv[1]), .init_busy(db[1]));

  ram_sdp_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .RDW_MODE(0), .OUT_REG(1), .CLEAR_VAL(16'h0000))
  u_dut2 (.clk(clk), .rst_n(rst_n), .we(we), .write_addr(wa), .data(din), .be(be), .re(re),
          .read_addr(ra), .clr(clr), .q(dq[2]), .q_valid(dv[2]), .init_busy(db[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n, input logic [1:0] b);
    return {b[1] ? n[15:8] : o[15:8], b[0] ? n[7:0] : o[7:0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      busy[k] = DEP[k];
      eq[k]   = 16'h0000;
      ev[k]   = 1'b0;
      for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
    end
  endtask

  // One clock edge of the reference: sweep countdown, clr, read then write,
  // results scheduled on a small time wheel LAT edges ahead.
  task automatic model_step();
    logic [15:0] rv;
    int          sp;
    int          sn;
    for (int k = 0; k < 3; k++) begin
      if (busy[k] > 0) begin
        busy[k]--;
        if (busy[k] == 0) begin
          for (int a = 0; a < DEP[k]; a++) mm[k][a] = 16'h0000;
        end
      end else if (clr) begin
        busy[k] = DEP[k];
      end else begin
        if (re) begin
          rv = (int'(ra) < DEP[k]) ? mm[k][ra] : 16'h0000;
          if (RDWM[k] == 1 && we && wa == ra && int'(wa) < DEP[k]) rv = merge16(rv, din, be);
          sp = (cyc + LAT[k] - 1) % 4;
          sd[k][sp] = rv;
          sv[k][sp] = 1'b1;
        end
        if (we && int'(wa) < DEP[k]) mm[k][wa] = merge16(mm[k][wa], din, be);
      end
      sn = cyc % 4;
      if (sv[k][sn]) begin
        ev[k] = 1'b1;
        eq[k] = sd[k][sn];
        sv[k][sn] = 1'b0;
      end else begin
        ev[k] = 1'b0;
      end
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  initial begin
    forever begin
      @(negedge rst_n);
      model_reset();
    end
  end

  // Cycle-by-cycle comparison of all three instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("cmp_q%0d", k), dq[k], eq[k]);
        chk($sformatf("cmp_valid%0d", k), dv[k], ev[k]);
        chk($sformatf("cmp_busy%0d", k), db[k], busy[k] > 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    we  = 1'b0;
    re  = 1'b0;
    clr = 1'b0;
    be  = 2'b00;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
    we = 1'b1; wa = a; din = d; be = b;
    step();
    idle();
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a, input logic [15:0] e0,
                        input logic [15:0] e1, input logic [15:0] e2);
    re = 1'b1; ra = a;
    step();
    idle();
    chk({nm, "_q0"}, dq[0], e0);
    chk({nm, "_v0"}, dv[0], 1'b1);
    chk({nm, "_q1"}, dq[1], e1);
    chk({nm, "_v2early"}, dv[2], 1'b0);
    step();
    chk({nm, "_v0pulse"}, dv[0], 1'b0);
    chk({nm, "_q2"}, dq[2], e2);
    chk({nm, "_v2"}, dv[2], 1'b1);
  endtask

  task automatic count_busy(output int c0, output int c2);
    c0 = 0;
    c2 = 0;
    for (int c = 0; c < 100; c++) begin
      if (db[0]) c0++;
      if (db[2]) c2++;
      step();
    end
  endtask

  initial begin
    int          c0;
    int          c2;
    logic [15:0] sexp [3];
    sexp[0] = 16'hAA55;
    sexp[1] = 16'hAB34;
    sexp[2] = 16'h0000;

    idle();
    repeat (3) step();
    chk("rst_q0", dq[0], 16'h0000);
    chk("rst_busy0", db[0], 1'b1);
    rst_n = 1'b1;
    count_busy(c0, c2);
    chk("busy_len0", c0, 64);
    chk("busy_len2", c2, 48);

    rd_chk("rd_3f", 6'h3F, 16'h0000, 16'h0000, 16'h0000);
    wr(6'h00, 16'hAA55, 2'b11);
    rd_chk("rd_00", 6'h00, 16'hAA55, 16'hAA55, 16'hAA55);

    wr(6'h01, 16'h1234, 2'b01);
    wr(6'h01, 16'hAB00, 2'b10);
    rd_chk("rd_01_be", 6'h01, 16'hAB34, 16'hAB34, 16'hAB34);
    wr(6'h01, 16'hFFFF, 2'b00);
    rd_chk("rd_01_be0", 6'h01, 16'hAB34, 16'hAB34, 16'hAB34);

    wr(6'h0A, 16'h00FF, 2'b11);
    we = 1'b1; wa = 6'h0A; din = 16'hBEEF; be = 2'b11; re = 1'b1; ra = 6'h0A;
    step();
    idle();
    chk("rdw_old0", dq[0], 16'h00FF);
    chk("rdw_new1", dq[1], 16'hBEEF);
    step();
    chk("rdw_old2", dq[2], 16'h00FF);
    rd_chk("rd_0a", 6'h0A, 16'hBEEF, 16'hBEEF, 16'hBEEF);

    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        re = 1'b1;
        ra = 6'(i);
      end else begin
        re = 1'b0;
      end
      step();
      if (i < 3) chk("strm_q0", dq[0], sexp[i]);
      chk("strm_v0", dv[0], i < 3);
      if (i >= 1 && i < 4) chk("strm_q2", dq[2], sexp[i-1]);
      chk("strm_v2", dv[2], i >= 1 && i < 4);
    end

    wr(6'h30, 16'h1357, 2'b11);
    rd_chk("rd_30", 6'h30, 16'h1357, 16'h1357, 16'h0000);

    clr = 1'b1;
    step();
    idle();
    chk("clr_busy0", db[0], 1'b1);
    repeat (19) step();
    chk("q_hold_init", dq[0], 16'h1357);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_q0", dq[0], 16'h0000);
    chk("rst_mid_v0", dv[0], 1'b0);
    chk("rst_mid_q1", dq[1], 16'h0000);
    repeat (3) step();
    rst_n = 1'b1;
    count_busy(c0, c2);
    chk("busy_len0_re", c0, 64);
    chk("busy_len2_re", c2, 48);

    wr(6'h02, 16'h7777, 2'b11);
    rd_chk("rd_02_pre", 6'h02, 16'h7777, 16'h7777, 16'h7777);
    we = 1'b1; wa = 6'h02; din = 16'h5555; be = 2'b11; clr = 1'b1;
    step();
    idle();
    chk("clr_busy0b", db[0], 1'b1);
    chk("clr_busy2b", db[2], 1'b1);
    repeat (70) step();
    rd_chk("rd_02_clr", 6'h02, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
